// File: rtl/instruction_queue_rs_if.sv
// Decode-to-dispatch bundle for instruction_queue_rs: enqueue side, per-station
// readiness, dispatch strobe and occupancy status.
interface instruction_queue_rs_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned INSTR_W = 75,
    parameter int unsigned NUM_RS  = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush_in;
    logic               enq_valid_in;
    logic [INSTR_W-1:0] enq_instr_in;
    logic               stall_out;
    logic [NUM_RS-1:0]  rs_ready_in;
    logic               rob_ready_in;
    logic               stall_in;
    logic               dispatch_valid_out;
    logic [NUM_RS-1:0]  dispatch_rs_out;
    logic [INSTR_W-1:0] dispatch_instr_out;
    logic               illegal_op_out;
    logic [CNT_W-1:0]   count_out;

    modport master (
        output flush_in, enq_valid_in, enq_instr_in, rs_ready_in, rob_ready_in, stall_in,
        input  stall_out, dispatch_valid_out, dispatch_rs_out, dispatch_instr_out,
        input  illegal_op_out, count_out
    );

    modport slave (
        input  flush_in, enq_valid_in, enq_instr_in, rs_ready_in, rob_ready_in, stall_in,
        output stall_out, dispatch_valid_out, dispatch_rs_out, dispatch_instr_out,
        output illegal_op_out, count_out
    );
endinterface

// File: rtl/instruction_queue_rs.sv
// In-order instruction queue feeding the reservation stations: circular FIFO whose head is
// routed by major opcode and issued only when its station and the ROB both have room.
module instruction_queue_rs #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned INSTR_W = 75,
    parameter int unsigned NUM_RS  = 5,
    parameter logic [63:0] RS_MAP  = 64'h0
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_queue_rs_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               illegal_q;

    logic [INSTR_W-1:0] head_instr;
    logic [3:0]         major;
    logic [3:0]         cls;
    logic [NUM_RS-1:0]  cls_onehot;
    logic               mapped;
    logic               not_empty;
    logic               enq_ready;
    logic               enq_fire;
    logic               issue_ok;
    logic               rs_ok;
    logic               fire;
    logic               discard;
    logic               pop;

    assign head_instr = mem_q[head_q];
    assign major      = head_instr[INSTR_W-1 -: 4];
    assign cls        = RS_MAP[{major, 2'b00} +: 4];

    // One-hot decode doubles as the "mapped" test: no bit set means cls >= NUM_RS.
    always_comb begin
        cls_onehot = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (cls == 4'(i)) cls_onehot[i] = 1'b1;
        end
    end

    assign mapped    = |cls_onehot;
    assign not_empty = (count_q != '0);
    assign enq_ready = (count_q < FULL_CNT);
    assign enq_fire  = bus.enq_valid_in && enq_ready && !bus.flush_in;
    assign issue_ok  = not_empty && !bus.stall_in && !bus.flush_in;
    assign rs_ok     = |(cls_onehot & bus.rs_ready_in);
    assign fire      = issue_ok && mapped && rs_ok && bus.rob_ready_in;
    assign discard   = issue_ok && !mapped;
    assign pop       = fire || discard;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (pop)      head_d = head_q + PTR_W'(1);
            unique case ({enq_fire, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            illegal_q <= discard;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[tail_q] <= bus.enq_instr_in;
    end

    assign bus.stall_out          = !enq_ready;
    assign bus.dispatch_valid_out = fire;
    assign bus.dispatch_rs_out    = fire ? cls_onehot : '0;
    assign bus.dispatch_instr_out = head_instr;
    assign bus.illegal_op_out     = illegal_q;
    assign bus.count_out          = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT);
    a_no_double:   assert property (@(posedge clk) disable iff (!rst_n) !(fire && discard));
endmodule

// File: tb/tb_instruction_queue_rs.sv
// Randomised scoreboard bench for instruction_queue_rs against a queue-based reference model.
`timescale 1ns/1ps
module tb_instruction_queue_rs;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IW    = 75;
    localparam int unsigned NRS   = 5;
    localparam logic [NRS-1:0] ALL = 5'b11111;

    typedef struct {
        int            cyc;
        logic [IW-1:0] instr;
        logic [NRS-1:0] rs;
    } exp_t;

    // Station for each major opcode; values >= NRS are unmapped.
    int map_tbl[16] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 7, 15};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [IW-1:0] model[$];
    exp_t          exp_q[$];
    int            exp_ill[$];

    instruction_queue_rs_if #(.DEPTH(DEPTH), .INSTR_W(IW), .NUM_RS(NRS)) bus ();

    instruction_queue_rs #(
        .DEPTH  (DEPTH),
        .INSTR_W(IW),
        .NUM_RS (NRS),
        .RS_MAP (64'hF732_1043_2104_3210)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] rinstr(input int major);
        logic [IW-1:0] v;
        v[31:0]     = $urandom;
        v[63:32]    = $urandom;
        v[IW-1:64]  = 11'($urandom);
        v[IW-1 -: 4] = 4'(major);
        return v;
    endfunction

    // Drive one cycle of stimulus and advance the reference model across the coming edge.
    task automatic cycle(input logic fl, input logic ev, input logic [IW-1:0] ins,
                         input logic [NRS-1:0] rs, input logic rob, input logic st);
        int   n;
        int   c;
        bit   fire;
        bit   ill;
        exp_t e;
        @(negedge clk);
        cyc++;
        bus.flush_in     = fl;
        bus.enq_valid_in = ev;
        bus.enq_instr_in = ins;
        bus.rs_ready_in  = rs;
        bus.rob_ready_in = rob;
        bus.stall_in     = st;
        #1;
        n = model.size();
        chk("count", longint'(bus.count_out), longint'(n));
        chk("stall_out", longint'(bus.stall_out), longint'(n == DEPTH));
        fire = 1'b0;
        ill  = 1'b0;
        c    = 0;
        if (n > 0 && !fl && !st) begin
            c = map_tbl[int'(model[0][IW-1 -: 4])];
            if (c >= NRS) ill = 1'b1;
            else if (rs[c] && rob) fire = 1'b1;
        end
        if (fire) begin
            e.cyc   = cyc;
            e.instr = model[0];
            e.rs    = NRS'(1) << c;
            exp_q.push_back(e);
        end
        if (ill) exp_ill.push_back(cyc);
        if (fl) begin
            model.delete();
        end else begin
            if (fire || ill) void'(model.pop_front());
            if (ev && n < DEPTH) model.push_back(ins);
        end
    endtask

    task automatic idle(input int k, input logic [NRS-1:0] rs);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, '0, rs, 1'b1, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.dispatch_valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dispatch", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dispatch_cycle", longint'(cyc), longint'(e.cyc));
                        checks++;
                        if (bus.dispatch_instr_out !== e.instr) begin
                            errors++;
                            $display("FAIL dispatch_instr actual %h required %h (cycle %0d)",
                                     bus.dispatch_instr_out, e.instr, cyc);
                        end
                        chk("dispatch_rs", longint'(bus.dispatch_rs_out), longint'(e.rs));
                    end
                end else begin
                    chk("rs_idle", longint'(bus.dispatch_rs_out), 0);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("missed_dispatch", 0, longint'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
                if (bus.illegal_op_out) begin
                    if (exp_ill.size() > 0 && exp_ill[0] == cyc - 1) begin
                        chk("illegal_pulse", 1, 1);
                        void'(exp_ill.pop_front());
                    end else begin
                        chk("unexpected_illegal", 1, 0);
                    end
                end
                if (exp_ill.size() > 0 && exp_ill[0] < cyc - 1) begin
                    chk("missed_illegal", 0, longint'(exp_ill[0]));
                    void'(exp_ill.pop_front());
                end
            end
        end
    end

    initial begin
        bus.flush_in     = 1'b0;
        bus.enq_valid_in = 1'b0;
        bus.enq_instr_in = '0;
        bus.rs_ready_in  = '0;
        bus.rob_ready_in = 1'b0;
        bus.stall_in     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", longint'(bus.count_out), 0);
        chk("reset_valid", longint'(bus.dispatch_valid_out), 0);
        chk("reset_illegal", longint'(bus.illegal_op_out), 0);
        chk("reset_stall", longint'(bus.stall_out), 0);
        #2 rst_n = 1'b1;

        // Fill with integer ops while stations are busy; the ninth is refused.
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, rinstr(0), '0, 1'b1, 1'b0);
        idle(1, '0);
        idle(DEPTH + 2, ALL);

        // Blocked fp-mul head holds back a ready integer op.
        cycle(1'b0, 1'b1, rinstr(2), 5'b11011, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, rinstr(0), 5'b11011, 1'b1, 1'b0);
        idle(2, 5'b11011);
        idle(3, ALL);

        // ROB full and global stall gating, then release.
        cycle(1'b0, 1'b1, rinstr(4), ALL, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, ALL, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, ALL, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, ALL, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, ALL, 1'b1, 1'b1);
        idle(2, ALL);

        // Steady stream at occupancy 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rinstr(1), '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b1, rinstr(int'($urandom_range(0, 13))), ALL, 1'b1, 1'b0);
        idle(5, ALL);

        // Unmapped opcodes are discarded with a one-cycle pulse.
        cycle(1'b0, 1'b1, rinstr(15), ALL, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, rinstr(0), ALL, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, rinstr(14), ALL, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, rinstr(3), ALL, 1'b1, 1'b0);
        idle(4, ALL);

        // Flush at occupancy 5 with a same-cycle enqueue.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rinstr(i), '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, rinstr(0), ALL, 1'b1, 1'b0);
        idle(3, ALL);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'b0 ^ ($urandom_range(0, 24) == 0), $urandom_range(0, 3) != 0,
                  rinstr(int'($urandom_range(0, 15))), NRS'($urandom),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0);
        idle(DEPTH + 2, ALL);

        // Asynchronous reset between edges while entries are queued.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rinstr(0), '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, rinstr(0), ALL, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", longint'(bus.count_out), 0);
        chk("async_rst_valid", longint'(bus.dispatch_valid_out), 0);
        model.delete();
        exp_ill.delete();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 60; i++)
            cycle(1'b0, $urandom_range(0, 1) != 0, rinstr(int'($urandom_range(0, 15))),
                  NRS'($urandom), 1'b1, 1'b0);
        idle(DEPTH + 3, ALL);

        chk("drain_dispatch_q", longint'(exp_q.size()), 0);
        chk("drain_illegal_q", longint'(exp_ill.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_queue_rs.md
Name: instruction_queue_rs

Overview:
- Parametrised in-order instruction queue between decode and the reservation stations (RS).
- Buffers packed decoded instructions in a circular FIFO of DEPTH entries.
- Routes the head entry to one of NUM_RS stations using a per-major-opcode map, and dispatches only when that station and the reorder buffer (ROB) both have space.
- Strict FIFO: a blocked head blocks every younger entry. Supports flush on mispredict/exception.

Parameters:
- DEPTH, 8: queue entries; power of 2, at least 2.
- INSTR_W, 75: packed instruction width. Major opcode is bits [INSTR_W-1:INSTR_W-4].
- NUM_RS, 5: number of destination stations. Index 0 integer, 1 fp add, 2 fp mul, 3 load/store, 4 branch.
- RS_MAP, 64'h0: 16 fields of 4 bits. Field k, bits [4k+3:4k], is the station index for major opcode k.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_in  input  1  discard all queued entries.
- enq_valid_in  input  1  decode presents an instruction.
- enq_instr_in  input  INSTR_W  packed instruction.
- stall_out  output  1  queue full; decode must hold. Equals !enq_ready.
- rs_ready_in  input  NUM_RS  per-station free-slot indication.
- rob_ready_in  input  1  ROB can accept an entry.
- stall_in  input  1  global dispatch hold.
- dispatch_valid_out  output  1  head is issuing this cycle.
- dispatch_rs_out  output  NUM_RS  one-hot target station, qualified by dispatch_valid_out.
- dispatch_instr_out  output  INSTR_W  head entry contents.
- illegal_op_out  output  1  one-cycle pulse when an unmapped head entry is discarded.
- count_out  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage is DEPTH x INSTR_W, with head and tail pointers of $clog2(DEPTH) bits that wrap naturally. Occupancy counter runs 0..DEPTH.
- Reset (async, rst_n low): head, tail and count are 0. All registered outputs are 0: dispatch_valid_out 0, illegal_op_out 0, count_out 0. stall_out is 0. Entry contents do not matter. Reset mid-operation drops all entries immediately; there is no partial dispatch.
- Enqueue: enq_ready = (count < DEPTH). An entry is written at the tail on the rising edge when enq_valid_in && enq_ready. Full does not accept an enqueue even if a dispatch fires in the same cycle (no full bypass).
- Head class: cls = RS_MAP[4*major+3 : 4*major], where major is the head's major opcode. Mapped when cls < NUM_RS.
- Dispatch (combinational from the head register; fires at the edge):
  - fire = (count != 0) && mapped && rs_ready_in[cls] && rob_ready_in && !stall_in && !flush_in.
  - dispatch_valid_out = fire.
  - dispatch_rs_out = fire ? (1 << cls) : 0.
  - dispatch_instr_out = head entry, always driven.
  - On fire, head advances by 1 at the edge.
- Illegal: when count != 0, the head is unmapped, and there is no stall_in/flush_in, the head is discarded at the edge. illegal_op_out pulses high the following cycle (registered). No RS strobe and no ROB consumption occur.
- Latency: an instruction enqueued at edge N is visible at the head no earlier than the cycle after edge N. There is no empty-queue bypass.
- Simultaneous enqueue and dispatch (or enqueue and illegal discard) when not full: count is unchanged and both pointers move.
- Flush: has priority over all other activity. At the edge, head = tail = count = 0 and any same-cycle enqueue is dropped. dispatch_valid_out is 0 in the flush cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Full and empty are distinguished only by count.
- stall_in only blocks dispatch. Enqueue continues until full.

Test Plan:
- Reset then fill: enqueue 8 integer ops (major 0, RS_MAP field 0 = 0), all rs_ready_in held 0 -> count_out = 8, stall_out = 1 on the 9th attempt, 9th instruction not stored.
- In-order blocking: head fp mul (cls 2) with rs_ready_in = 5'b11011, next entry integer -> no dispatch. Set bit 2 -> mul dispatches with dispatch_rs_out = 5'b00100, integer dispatches the next cycle with 5'b00001.
- ROB/stall gating: head ready, rob_ready_in = 0 or stall_in = 1 -> dispatch_valid_out = 0 and count unchanged. Release -> dispatches in the same cycle.
- Wrap-around and simultaneous events: 20 entries streamed with enqueue and dispatch every cycle at count = 3 -> count_out stays 3 and output order matches input order across pointer wrap.
- Illegal op: RS_MAP field 15 = 4'hF, enqueue major 15 then a valid op -> illegal_op_out pulses one cycle, no dispatch strobe, valid op dispatches next.
- Flush and async reset: count = 5 with flush_in and enq_valid_in together -> count_out = 0 and queue empty. Assert rst_n low mid-stream between edges -> count_out = 0 and dispatch_valid_out = 0 immediately.
